gelato_fetch_scheduler: RTL and testbench

GELATO_FETCH_SCHEDULER -- requirements
Module: gelato_fetch_scheduler

---
 rtl/gelato_fetch_scheduler_if.sv | 39 +++
 rtl/gelato_fetch_scheduler.sv | 83 ++++++++
 tb/tb_gelato_fetch_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/gelato_fetch_scheduler_if.sv
// gelato_fetch_scheduler_if: warp lifecycle commands in, fetch requests out
// launch_*/resume_*/exit_* : warp events from the core (master -> slave)
// ifetch_ready             : I-Fetch accept (master -> slave)
// ifetch_*, active_mask    : fetch request and live-warp mask (slave -> master)
interface gelato_fetch_scheduler_if #(
  parameter int NUM_WARPS   = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int SPLIT_WIDTH = 3
) ();
  localparam int WARP_WIDTH = $clog2(NUM_WARPS);
  logic                   launch_valid;
  logic [WARP_WIDTH-1:0]  launch_warp;
  logic [ADDR_WIDTH-1:0]  launch_pc;
  logic [SPLIT_WIDTH-1:0] launch_split;
  logic                   resume_valid;
  logic [WARP_WIDTH-1:0]  resume_warp;
  logic [ADDR_WIDTH-1:0]  resume_pc;
  logic [SPLIT_WIDTH-1:0] resume_split;
  logic                   exit_valid;
  logic [WARP_WIDTH-1:0]  exit_warp;
  logic                   ifetch_ready;
  logic                   ifetch_valid;
  logic [ADDR_WIDTH-1:0]  ifetch_pc;
  logic [WARP_WIDTH-1:0]  ifetch_warp_num;
  logic [SPLIT_WIDTH-1:0] ifetch_split_table_num;
  logic [NUM_WARPS-1:0]   active_mask;
  modport master (
    output launch_valid, launch_warp, launch_pc, launch_split,
    output resume_valid, resume_warp, resume_pc, resume_split,
    output exit_valid, exit_warp, ifetch_ready,
    input  ifetch_valid, ifetch_pc, ifetch_warp_num, ifetch_split_table_num, active_mask
  );
  modport slave (
    input  launch_valid, launch_warp, launch_pc, launch_split,
    input  resume_valid, resume_warp, resume_pc, resume_split,
    input  exit_valid, exit_warp, ifetch_ready,
    output ifetch_valid, ifetch_pc, ifetch_warp_num, ifetch_split_table_num, active_mask
  );
endinterface

// File: rtl/gelato_fetch_scheduler.sv
// gelato_fetch_scheduler: round-robin per-warp fetch request scheduler
// clk, rst_n : clock, asynchronous active-low reset
// bus        : slave side of gelato_fetch_scheduler_if (warp events in, fetch request out)
module gelato_fetch_scheduler #(
  parameter int NUM_WARPS   = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int SPLIT_WIDTH = 3
) (
  input logic clk,
  input logic rst_n,
  gelato_fetch_scheduler_if.slave bus
);
  localparam int WARP_WIDTH = $clog2(NUM_WARPS);
  typedef enum logic [1:0] {IDLE, READY, INFLIGHT} wstate_t;
  wstate_t                st   [NUM_WARPS];
  wstate_t                st_n [NUM_WARPS];
  logic [ADDR_WIDTH-1:0]  pc   [NUM_WARPS];
  logic [SPLIT_WIDTH-1:0] split[NUM_WARPS];
  logic [NUM_WARPS-1:0]   lw, rw, cand;
  logic [WARP_WIDTH-1:0]  rr_ptr, sel, idx;
  logic                   found, hs, free, kill;
  assign hs   = bus.ifetch_valid && bus.ifetch_ready;
  assign free = !bus.ifetch_valid || hs;
  assign kill = bus.ifetch_valid && bus.exit_valid && bus.exit_warp == bus.ifetch_warp_num;
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      lw[i] = bus.launch_valid && bus.launch_warp == WARP_WIDTH'(i) && st[i] == IDLE;
      rw[i] = bus.resume_valid && bus.resume_warp == WARP_WIDTH'(i) && st[i] == INFLIGHT;
      // a warp being exited this cycle must not be loaded into the output register
      cand[i] = st[i] == READY && !(bus.ifetch_valid && bus.ifetch_warp_num == WARP_WIDTH'(i))
                && !(bus.exit_valid && bus.exit_warp == WARP_WIDTH'(i));
      st_n[i] = st[i];
      if (hs && bus.ifetch_warp_num == WARP_WIDTH'(i)) st_n[i] = INFLIGHT;
      if (lw[i] || rw[i]) st_n[i] = READY;
      if (bus.exit_valid && bus.exit_warp == WARP_WIDTH'(i)) st_n[i] = IDLE;
      bus.active_mask[i] = st[i] != IDLE;
    end
  end
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = rr_ptr + WARP_WIDTH'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        st[i]    <= IDLE;
        pc[i]    <= '0;
        split[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        st[i]    <= st_n[i];
        pc[i]    <= lw[i] ? bus.launch_pc : rw[i] ? bus.resume_pc : pc[i];
        split[i] <= lw[i] ? bus.launch_split : rw[i] ? bus.resume_split : split[i];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ifetch_valid           <= 1'b0;
      bus.ifetch_pc              <= '0;
      bus.ifetch_warp_num        <= '0;
      bus.ifetch_split_table_num <= '0;
      rr_ptr                     <= '0;
    end else if (free && found) begin
      bus.ifetch_valid           <= 1'b1;
      bus.ifetch_pc              <= pc[sel];
      bus.ifetch_warp_num        <= sel;
      bus.ifetch_split_table_num <= split[sel];
      rr_ptr                     <= sel + WARP_WIDTH'(1);
    end else if (free || kill) begin
      bus.ifetch_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// tb_gelato_fetch_scheduler: directed self-checking bench for gelato_fetch_scheduler
module tb_gelato_fetch_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  gelato_fetch_scheduler_if #(.NUM_WARPS(8), .ADDR_WIDTH(32), .SPLIT_WIDTH(3)) bus ();
  gelato_fetch_scheduler #(.NUM_WARPS(8), .ADDR_WIDTH(32), .SPLIT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_req(input string tag, input logic [31:0] p, input logic [2:0] w, input logic [2:0] s);
    chk({tag, ".valid"}, 64'(bus.ifetch_valid), 64'd1);
    chk({tag, ".pc"}, 64'(bus.ifetch_pc), 64'(p));
    chk({tag, ".warp"}, 64'(bus.ifetch_warp_num), 64'(w));
    chk({tag, ".split"}, 64'(bus.ifetch_split_table_num), 64'(s));
  endtask
  task automatic quiet();
    bus.launch_valid = 1'b0;
    bus.resume_valid = 1'b0;
    bus.exit_valid   = 1'b0;
  endtask
  task automatic launch(input logic [2:0] w, input logic [31:0] p, input logic [2:0] s);
    bus.launch_valid = 1'b1;
    bus.launch_warp  = w;
    bus.launch_pc    = p;
    bus.launch_split = s;
  endtask
  task automatic resume(input logic [2:0] w, input logic [31:0] p, input logic [2:0] s);
    bus.resume_valid = 1'b1;
    bus.resume_warp  = w;
    bus.resume_pc    = p;
    bus.resume_split = s;
  endtask
  task automatic exit_w(input logic [2:0] w);
    bus.exit_valid = 1'b1;
    bus.exit_warp  = w;
  endtask
  initial begin
    quiet();
    bus.launch_warp = '0; bus.launch_pc = '0; bus.launch_split = '0;
    bus.resume_warp = '0; bus.resume_pc = '0; bus.resume_split = '0;
    bus.exit_warp = '0;
    bus.ifetch_ready = 1'b0;
    tick(); tick();
    chk("rst.valid", 64'(bus.ifetch_valid), 64'd0);
    chk("rst.pc", 64'(bus.ifetch_pc), 64'd0);
    chk("rst.warp", 64'(bus.ifetch_warp_num), 64'd0);
    chk("rst.split", 64'(bus.ifetch_split_table_num), 64'd0);
    chk("rst.mask", 64'(bus.active_mask), 64'h00);
    rst_n = 1'b1;
    tick();
    // single launch, one fetch, no repeat
    bus.ifetch_ready = 1'b1;
    launch(3'd3, 32'h1000, 3'd2);
    tick(); quiet();
    chk("l3.mask", 64'(bus.active_mask), 64'h08);
    chk("l3.lat", 64'(bus.ifetch_valid), 64'd0);
    tick();
    chk_req("l3.req", 32'h1000, 3'd3, 3'd2);
    tick();
    chk("l3.done", 64'(bus.ifetch_valid), 64'd0);
    tick(); tick();
    chk("l3.norepeat", 64'(bus.ifetch_valid), 64'd0);
    chk("l3.mask2", 64'(bus.active_mask), 64'h08);
    // three launches, then back-to-back fetches
    bus.ifetch_ready = 1'b0;
    launch(3'd0, 32'h0100, 3'd0);
    tick();
    launch(3'd1, 32'h0200, 3'd1);
    tick();
    chk_req("rr.w0", 32'h0100, 3'd0, 3'd0);
    launch(3'd2, 32'h0300, 3'd3);
    tick(); quiet();
    chk_req("rr.hold0", 32'h0100, 3'd0, 3'd0);
    bus.ifetch_ready = 1'b1;
    tick();
    chk_req("rr.w1", 32'h0200, 3'd1, 3'd1);
    tick();
    chk_req("rr.w2", 32'h0300, 3'd2, 3'd3);
    tick();
    chk("rr.empty", 64'(bus.ifetch_valid), 64'd0);
    chk("rr.mask", 64'(bus.active_mask), 64'h0F);
    // resume 0,1,2 -> same order again
    resume(3'd0, 32'h0A00, 3'd4);
    tick();
    resume(3'd1, 32'h0B00, 3'd5);
    tick();
    chk_req("res.w0", 32'h0A00, 3'd0, 3'd4);
    resume(3'd2, 32'h0C00, 3'd6);
    tick(); quiet();
    chk_req("res.w1", 32'h0B00, 3'd1, 3'd5);
    tick();
    chk_req("res.w2", 32'h0C00, 3'd2, 3'd6);
    tick();
    chk("res.empty", 64'(bus.ifetch_valid), 64'd0);
    // wrap: 6, 7, then 0
    bus.ifetch_ready = 1'b0;
    launch(3'd6, 32'h0600, 3'd1);
    tick();
    launch(3'd7, 32'h0700, 3'd2);
    tick(); quiet();
    chk("wrap.w6", 64'(bus.ifetch_warp_num), 64'd6);
    resume(3'd0, 32'h0D00, 3'd7);
    tick(); quiet();
    bus.ifetch_ready = 1'b1;
    tick();
    chk_req("wrap.w7", 32'h0700, 3'd7, 3'd2);
    tick();
    chk_req("wrap.w0", 32'h0D00, 3'd0, 3'd7);
    tick();
    chk("wrap.empty", 64'(bus.ifetch_valid), 64'd0);
    chk("wrap.mask", 64'(bus.active_mask), 64'hCF);
    // stall with warp 5 pending for 5 cycles
    bus.ifetch_ready = 1'b0;
    launch(3'd5, 32'h5550, 3'd5);
    tick(); quiet();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_req($sformatf("stall.c%0d", i), 32'h5550, 3'd5, 3'd5);
    end
    bus.ifetch_ready = 1'b1;
    tick();
    chk("stall.hs", 64'(bus.ifetch_valid), 64'd0);
    tick();
    chk("stall.single", 64'(bus.ifetch_valid), 64'd0);
    chk("stall.mask", 64'(bus.active_mask), 64'hEF);
    // exit while pending and stalled
    bus.ifetch_ready = 1'b0;
    launch(3'd4, 32'h4000, 3'd0);
    tick(); quiet();
    tick();
    chk_req("exit.pend", 32'h4000, 3'd4, 3'd0);
    chk("exit.mask0", 64'(bus.active_mask), 64'hFF);
    exit_w(3'd4);
    tick(); quiet();
    chk("exit.valid", 64'(bus.ifetch_valid), 64'd0);
    chk("exit.mask", 64'(bus.active_mask), 64'hEF);
    // same-cycle resume/launch, ignored launches to active warps
    exit_w(3'd6);
    tick(); quiet();
    chk("mix.exit6", 64'(bus.active_mask), 64'hAF);
    resume(3'd2, 32'h2200, 3'd1);
    launch(3'd6, 32'h6600, 3'd6);
    tick(); quiet();
    chk("mix.mask", 64'(bus.active_mask), 64'hEF);
    chk("mix.lat", 64'(bus.ifetch_valid), 64'd0);
    launch(3'd1, 32'hDEAD, 3'd7);
    tick(); quiet();
    chk_req("mix.w6", 32'h6600, 3'd6, 3'd6);
    launch(3'd2, 32'hBEEF, 3'd0);
    tick(); quiet();
    chk("mix.mask2", 64'(bus.active_mask), 64'hEF);
    bus.ifetch_ready = 1'b1;
    tick();
    chk_req("mix.w2", 32'h2200, 3'd2, 3'd1);
    tick();
    chk("mix.no_w1", 64'(bus.ifetch_valid), 64'd0);
    // asynchronous reset mid-stall
    bus.ifetch_ready = 1'b0;
    launch(3'd4, 32'h4440, 3'd3);
    tick(); quiet();
    tick();
    chk_req("ar.pend", 32'h4440, 3'd4, 3'd3);
    chk("ar.mask0", 64'(bus.active_mask), 64'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(bus.ifetch_valid), 64'd0);
    chk("ar.pc", 64'(bus.ifetch_pc), 64'd0);
    chk("ar.warp", 64'(bus.ifetch_warp_num), 64'd0);
    chk("ar.split", 64'(bus.ifetch_split_table_num), 64'd0);
    chk("ar.mask", 64'(bus.active_mask), 64'h00);
    tick(); tick();
    rst_n = 1'b1;
    bus.ifetch_ready = 1'b1;
    launch(3'd3, 32'h3000, 3'd4);
    tick(); quiet();
    chk("post.lat", 64'(bus.ifetch_valid), 64'd0);
    chk("post.mask", 64'(bus.active_mask), 64'h08);
    tick();
    chk_req("post.w3", 32'h3000, 3'd3, 3'd4);
    tick();
    chk("post.done", 64'(bus.ifetch_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
